// File: rtl/garage_pkg.sv
// garage_pkg: shared ramp FSM states plus status and direction encodings for the garage blocks
package garage_pkg;
   typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;
   localparam logic STATUS_SLOTS = 1'b0;
   localparam logic STATUS_FULL  = 1'b1;
   localparam logic DIR_IN       = 1'b1;
   localparam logic DIR_OUT      = 1'b0;
endpackage

// File: rtl/garage_occupancy_counter.sv
// garage_occupancy_counter: saturating up/down car count with full flag and last-slot warning
// nearly_full is driven only when GARAGE_LAST_SLOT_WARN_EN is defined, otherwise tied low
module garage_occupancy_counter
   import garage_pkg::*;
#(
   parameter int CAPACITY = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             status,
   output logic             nearly_full
);
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (inc && count != CNT_W'(CAPACITY)) count <= count + CNT_W'(1);
      else if (dec && count != '0) count <= count - CNT_W'(1);
   assign status = (count == CNT_W'(CAPACITY)) ? STATUS_FULL : STATUS_SLOTS;
`ifdef GARAGE_LAST_SLOT_WARN_EN
   assign nearly_full = count == CNT_W'(CAPACITY - 1);
`else
   assign nearly_full = 1'b0;
`endif
endmodule

// File: rtl/garage_ramp_controller.sv
// garage_ramp_controller: round-robin entry/exit arbitration, barrier sequencing and occupancy
// nearly_full is active only with GARAGE_LAST_SLOT_WARN_EN defined
module garage_ramp_controller
   import garage_pkg::*;
#(
   parameter int CAPACITY    = 8,
   parameter int CNT_W       = 4,
   parameter int OPEN_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   output logic             barrier_open,
   output logic             dir_in,
   output logic [CNT_W-1:0] count,
   output logic             status,
   output logic             nearly_full
);
   localparam int TW = $clog2(OPEN_CYCLES);
   state_t state, nxt;
   logic [TW-1:0] timer;
   logic rr_last, ent_ok, ext_ok, grant_in, timeout, is_open;
   assign ent_ok   = entry_req && status == STATUS_SLOTS;
   assign ext_ok   = exit_req && count != '0;
   assign grant_in = ent_ok && (!ext_ok || rr_last == DIR_OUT);
   assign timeout  = timer == TW'(OPEN_CYCLES - 1);
   assign is_open  = state == OPEN_IN || state == OPEN_OUT;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:              nxt = grant_in ? OPEN_IN : ext_ok ? OPEN_OUT : IDLE;
         OPEN_IN, OPEN_OUT: nxt = (car_passed || timeout) ? CLOSE : state;
         default:           nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         rr_last <= DIR_OUT;
      end else begin
         state   <= nxt;
         timer   <= (is_open && nxt == state) ? timer + TW'(1) : '0;
         rr_last <= (state == IDLE && nxt != IDLE) ? ((nxt == OPEN_IN) ? DIR_IN : DIR_OUT) : rr_last;
      end
   assign barrier_open = is_open;
   assign dir_in       = (state == OPEN_IN) ? DIR_IN : DIR_OUT;
   garage_occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (state == OPEN_IN && car_passed),
      .dec         (state == OPEN_OUT && car_passed),
      .count       (count),
      .status      (status),
      .nearly_full (nearly_full)
   );
endmodule

// File: tb/tb_garage_ramp_controller.sv
// tb_garage_ramp_controller: vector table, directed corner sequences and random traffic vs occupancy model
module tb_garage_ramp_controller;
   localparam int CAPACITY = 8, CNT_W = 4, OPEN_CYCLES = 16;
   logic clk = 0, rst = 0, entry_req = 0, exit_req = 0, car_passed = 0;
   logic barrier_open, dir_in, status, nearly_full;
   logic [CNT_W-1:0] count;
   int checks = 0, errors = 0;
   int occ = 0, m_el = 0;
   bit m_open = 0, m_close = 0, m_in = 0, m_last_in = 0;
   typedef struct {bit er, xr, cp, r, b, d, s; int c;} vec_t;
   vec_t tv[12];
   garage_ramp_controller #(.CAPACITY(CAPACITY), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN_CYCLES)) dut (
      .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
      .barrier_open(barrier_open), .dir_in(dir_in), .count(count), .status(status), .nearly_full(nearly_full));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model(input bit er, input bit xr, input bit cp, input bit r);
      bit e, x;
      if (r) begin
         occ = 0; m_open = 0; m_close = 0; m_last_in = 0;
      end else if (m_open) begin
         if (cp) begin
            occ += m_in ? 1 : -1; m_open = 0; m_close = 1;
         end else if (m_el == OPEN_CYCLES - 1) begin
            m_open = 0; m_close = 1;
         end else m_el++;
      end else if (m_close) m_close = 0;
      else begin
         e = er && occ < CAPACITY;
         x = xr && occ > 0;
         if (e || x) begin
            m_in = (e && x) ? !m_last_in : e;
            m_last_in = m_in; m_open = 1; m_el = 0;
         end
      end
   endtask
   task automatic step(input bit er, input bit xr, input bit cp, input bit r);
      int exp_nf;
      entry_req = er; exit_req = xr; car_passed = cp; rst = r;
      @(posedge clk);
      model(er, xr, cp, r);
      #1;
`ifdef GARAGE_LAST_SLOT_WARN_EN
      exp_nf = int'(occ == CAPACITY - 1);
`else
      exp_nf = 0;
`endif
      chk("barrier_open", int'(barrier_open), int'(m_open));
      if (m_open) chk("dir_in", int'(dir_in), int'(m_in));
      chk("count", int'(count), occ);
      chk("status", int'(status), int'(occ == CAPACITY));
      chk("nearly_full", int'(nearly_full), exp_nf);
   endtask
   task automatic grant_and_pass(input bit er, input bit xr, output bit d);
      int n = 0;
      while (!barrier_open && n < 40) begin
         step(er, xr, 0, 0);
         n++;
      end
      if (!barrier_open) chk("grant_timeout", 0, 1);
      d = dir_in;
      step(er, xr, 1, 0);
   endtask
   initial begin
      bit d;
      int n;
      tv[0]  = '{er:0, xr:0, cp:0, r:1, b:0, d:0, s:0, c:0};
      tv[1]  = '{er:1, xr:0, cp:0, r:0, b:1, d:1, s:0, c:0};
      tv[2]  = '{er:1, xr:0, cp:0, r:0, b:1, d:1, s:0, c:0};
      tv[3]  = '{er:1, xr:0, cp:0, r:0, b:1, d:1, s:0, c:0};
      tv[4]  = '{er:1, xr:0, cp:1, r:0, b:0, d:0, s:0, c:1};
      tv[5]  = '{er:0, xr:0, cp:0, r:0, b:0, d:0, s:0, c:1};
      tv[6]  = '{er:0, xr:1, cp:0, r:0, b:1, d:0, s:0, c:1};
      tv[7]  = '{er:0, xr:1, cp:1, r:0, b:0, d:0, s:0, c:0};
      tv[8]  = '{er:1, xr:0, cp:0, r:0, b:0, d:0, s:0, c:0};
      tv[9]  = '{er:1, xr:0, cp:0, r:0, b:1, d:1, s:0, c:0};
      tv[10] = '{er:0, xr:0, cp:1, r:0, b:0, d:0, s:0, c:1};
      tv[11] = '{er:0, xr:0, cp:1, r:0, b:0, d:0, s:0, c:1};
      for (int i = 0; i < 12; i++) begin
         step(tv[i].er, tv[i].xr, tv[i].cp, tv[i].r);
         chk($sformatf("tv%0d_barrier", i), int'(barrier_open), int'(tv[i].b));
         if (tv[i].b) chk($sformatf("tv%0d_dir", i), int'(dir_in), int'(tv[i].d));
         chk($sformatf("tv%0d_count", i), int'(count), tv[i].c);
         chk($sformatf("tv%0d_status", i), int'(status), int'(tv[i].s));
      end
      step(0, 0, 0, 1);
      for (int i = 0; i < CAPACITY; i++) begin
         grant_and_pass(1, 0, d);
         if (i == CAPACITY - 2) begin
`ifdef GARAGE_LAST_SLOT_WARN_EN
            chk("nf_at_7", int'(nearly_full), 1);
`else
            chk("nf_at_7", int'(nearly_full), 0);
`endif
         end
      end
      chk("full_count", int'(count), CAPACITY);
      chk("full_status", int'(status), 1);
      chk("full_nf", int'(nearly_full), 0);
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0);
         chk("full_held_off", int'(barrier_open), 0);
      end
      grant_and_pass(1, 1, d);
      chk("full_exit_dir", int'(d), 0);
      chk("exit_count", int'(count), CAPACITY - 1);
      chk("exit_status", int'(status), 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) grant_and_pass(1, 0, d);
      grant_and_pass(0, 1, d);
      chk("alt_start", int'(count), 3);
      for (int i = 0; i < 4; i++) begin
         grant_and_pass(1, 1, d);
         chk($sformatf("alt_dir%0d", i), int'(d), int'(i % 2 == 0));
         chk($sformatf("alt_cnt%0d", i), int'(count), (i % 2 == 0) ? 4 : 3);
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      n = 0;
      while (!barrier_open && n < 40) begin
         step(1, 0, 0, 0);
         n++;
      end
      n = barrier_open ? 1 : 0;
      while (barrier_open && n < 40) begin
         step(0, 0, 0, 0);
         if (barrier_open) n++;
      end
      chk("open_cycles", n, OPEN_CYCLES);
      chk("timeout_count", int'(count), 3);
      step(0, 0, 0, 0);
      grant_and_pass(1, 0, d);
      grant_and_pass(1, 0, d);
      chk("pre_rst_count", int'(count), 5);
      step(0, 0, 0, 0);
      n = 0;
      while (!barrier_open && n < 40) begin
         step(0, 1, 0, 0);
         n++;
      end
      chk("rst_open_out", int'(barrier_open && !dir_in), 1);
      step(0, 1, 0, 1);
      chk("rst_barrier", int'(barrier_open), 0);
      chk("rst_count", int'(count), 0);
      step(0, 0, 1, 0);
      chk("late_pass_count", int'(count), 0);
      chk("late_pass_barrier", int'(barrier_open), 0);
      for (int i = 0; i < 3000; i++)
         step(1'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 250) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
